data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised successor to the CPU data memory: a word-organised, byte-addressed data RAM with a valid/ready request port and a registered response port. Supports LB/LH/LW/LBU/LHU and SB/SH/SW. Misaligned accesses that cross a word boundary are split into two internal word accesses. Adds out-of-range and illegal-op error reporting and a sequential post-reset clear. Sits between the CPU MEM stage and the debug/readout logic.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of 2, at least 4.
BASE_ADDR, 32'h0000_0400, byte address of word 0.
CLEAR_ON_RESET, 1, 1 = zero every word after reset via the INIT sweep; 0 = contents undefined after reset.
IDX_W, $clog2(DEPTH_WORDS), word index width (derived; do not override).

Ports:
sys_clk  input  1  system clock; all state is updated on the rising edge.
sys_reset_n  input  1  asynchronous, active-low reset.
req_valid_i  input  1  request valid.
req_ready_o  output  1  request accepted when valid and ready are both 1 on a rising edge.
req_we_i  input  1  1 = store, 0 = load.
req_addr_i  input  32  byte address.
req_wdata_i  input  32  store data, right-aligned.
req_funct3_i  input  3  RISC-V funct3 access type.
rsp_valid_o  output  1  single-cycle response pulse.
rsp_rdata_o  output  32  load result, extended per funct3; 0 for stores and errors.
rsp_err_o  output  1  error flag, qualified by rsp_valid_o.
dbg_idx_i  input  IDX_W  debug word index.
dbg_data_o  output  32  combinational read of word dbg_idx_i.

Behaviour:
- Byte order is little-endian. off = req_addr_i - BASE_ADDR, computed on 32 bits. Word index = off[IDX_W+1:2]; lane = off[1:0].
- Access size is 1, 2 or 4 bytes for funct3[1:0] = 00, 01 or 10.
- Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Any other funct3 is an error.
- Range error: req_addr_i < BASE_ADDR, or off + size - 1 >= 4*DEPTH_WORDS. Accesses never wrap around the array.
- States: INIT, IDLE, SPLIT.
- Reset (asynchronous assert): state becomes INIT if CLEAR_ON_RESET=1, otherwise IDLE. req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, clear counter=0.
- INIT:
  - Writes 0 to word[counter] each cycle and increments the counter.
  - After word DEPTH_WORDS-1 is written, moves to IDLE. The sweep takes DEPTH_WORDS cycles.
  - req_ready_o=0 throughout.
- IDLE:
  - req_ready_o=1.
  - Error request: no memory write. Response at the next cycle with rsp_err_o=1 and rsp_rdata_o=0.
  - Access within one word (lane + size <= 4):
    - Store: byte-enabled write at the accept edge.
    - Load: result registered at the accept edge.
    - rsp_valid_o=1 on the cycle after accept (latency 1).
    - Back-to-back requests are accepted every cycle.
  - Access crossing a word boundary (lane + size > 4):
    - At the accept edge, the low bytes go to word idx (store) or are captured (load).
    - Move to SPLIT.
- SPLIT:
  - req_ready_o=0.
  - Accesses word idx+1 for the remaining bytes, then returns to IDLE.
  - Response is at accept+2.
- Load extension:
  - LB/LH sign-extend from bit 7 / bit 15 of the assembled value.
  - LBU/LHU zero-extend.
  - LW returns all 4 assembled bytes.
- Store response: rsp_valid_o pulses with rsp_rdata_o=0 and rsp_err_o=0.
- rsp_valid_o is high for exactly one cycle per accepted request. Responses come back in request order.
- dbg_data_o is purely combinational. It shows pre-write contents until the write edge.
- Reset during SPLIT aborts the access and produces no response. First-half bytes already written may remain when CLEAR_ON_RESET=0.
- A request with req_valid_i=1 during INIT is held off by req_ready_o=0 and is accepted once the block enters IDLE.

Test Plan:
- Reset, then release with DEPTH_WORDS=256 -> req_ready_o=0 for 256 cycles, then 1. dbg_data_o=0 for indices 0, 128 and 255.
- SW 0xDEADBEEF @0x400, then LW @0x400 -> rsp_rdata_o=0xDEADBEEF at accept+1. LB @0x400 returns 0xFFFFFFEF; LBU @0x401 returns 0x000000BE.
- SH 0x8001 @0x403 (crosses a word) -> req_ready_o=0 for 1 cycle; word0[31:24]=0x01, word1[7:0]=0x80. LH @0x403 returns 0xFFFF8001 at accept+2; LHU returns 0x00008001.
- Loads: LW @0x3FC gives err=1 (below base). LW @0x7FD gives err=1 (off+3=0x400, past end). Store with funct3=011 gives err=1, memory unchanged. All return rsp_rdata_o=0.
- Back-to-back SB to 0x404..0x407 with values 0x11..0x44 on consecutive cycles -> ready stays 1, 4 responses in order, word1=0x44332211.
- Assert sys_reset_n low during SPLIT of SW @0x406 -> no rsp_valid_o. After re-init, words 1 and 2 read 0.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Byte-addressed, word-organised data RAM with a valid/ready request port and a registered response.
// Word-crossing accesses take two cycles (IDLE then SPLIT); an optional INIT sweep zeroes the array after reset.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0400,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned IDX_W          = $clog2(DEPTH_WORDS)
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [2:0]       req_funct3_i,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_err_o,
  input  logic [IDX_W-1:0] dbg_idx_i,
  output logic [31:0]      dbg_data_o
);

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_SPLIT = 2'd2} state_e;

  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] v);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{v[7]}}, v[7:0]};
      3'b001:  r = {{16{v[15]}}, v[15:0]};
      3'b010:  r = v;
      3'b100:  r = {24'h000000, v[7:0]};
      3'b101:  r = {16'h0000, v[15:0]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return r;
  endfunction

  logic [31:0]      mem_q [DEPTH_WORDS];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             sp_we_q, sp_we_d;
  logic [2:0]       sp_f3_q, sp_f3_d;
  logic [1:0]       sp_lane_q, sp_lane_d;
  logic [IDX_W-1:0] sp_idx_q, sp_idx_d;
  logic [31:0]      sp_wdata_q, sp_wdata_d, sp_lo_q, sp_lo_d;
  logic [3:0]       sp_be_q, sp_be_d;

  logic [31:0]      off_s, lo_rd_s, hi_asm_s, mem_wdata_s;
  logic [32:0]      end_s;
  logic [IDX_W-1:0] idx_s, mem_widx_s;
  logic [1:0]       lane_s;
  logic [2:0]       size_s;
  logic [3:0]       mask_s, mem_be_s;
  logic [63:0]      wide_data_s;
  logic [7:0]       wide_be_s;
  logic             legal_s, err_s, cross_s, accept_s, mem_we_s;

  assign off_s       = req_addr_i - BASE_ADDR;
  assign lane_s      = off_s[1:0];
  assign idx_s       = off_s[IDX_W+1:2];
  assign end_s       = {1'b0, off_s} + {30'h0000_0000, size_s} - 33'd1;
  assign err_s       = ~legal_s | (req_addr_i < BASE_ADDR) | (end_s >= MEM_BYTES);
  assign cross_s     = (({1'b0, lane_s} + size_s) > 3'd4);
  assign wide_data_s = {32'h0000_0000, req_wdata_i} << {lane_s, 3'b000};
  assign wide_be_s   = {4'h0, mask_s} << lane_s;
  assign lo_rd_s     = mem_q[idx_s] >> {lane_s, 3'b000};
  assign hi_asm_s    = 32'({mem_q[sp_idx_q], sp_lo_q} >> {sp_lane_q, 3'b000});
  assign accept_s    = req_valid_i & ready_q;

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign dbg_data_o  = mem_q[dbg_idx_i];

  // Access size, byte mask and funct3 legality of the incoming request
  always_comb begin
    size_s = 3'd1;
    mask_s = 4'b0001;
    case (req_funct3_i[1:0])
      2'b00:   begin size_s = 3'd1; mask_s = 4'b0001; end
      2'b01:   begin size_s = 3'd2; mask_s = 4'b0011; end
      2'b10:   begin size_s = 3'd4; mask_s = 4'b1111; end
      default: begin size_s = 3'd1; mask_s = 4'b0001; end
    endcase
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: legal_s = 1'b1;
      3'b100, 3'b101:         legal_s = ~req_we_i;
      default:                legal_s = 1'b0;
    endcase
  end

  // Next state, memory write port and response for INIT / IDLE / SPLIT
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    sp_we_d     = sp_we_q;
    sp_f3_d     = sp_f3_q;
    sp_lane_d   = sp_lane_q;
    sp_idx_d    = sp_idx_q;
    sp_wdata_d  = sp_wdata_q;
    sp_be_d     = sp_be_q;
    sp_lo_d     = sp_lo_q;
    mem_we_s    = 1'b0;
    mem_widx_s  = idx_s;
    mem_wdata_s = wide_data_s[31:0];
    mem_be_s    = wide_be_s[3:0];
    case (state_q)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_widx_s  = clr_cnt_q;
        mem_wdata_s = 32'h0000_0000;
        mem_be_s    = 4'hF;
        clr_cnt_d   = clr_cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
        if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (err_s) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (cross_s) begin
          // Low bytes land now; the upper word is finished from the captured fields in SPLIT
          mem_we_s   = req_we_i;
          state_d    = ST_SPLIT;
          sp_we_d    = req_we_i;
          sp_f3_d    = req_funct3_i;
          sp_lane_d  = lane_s;
          sp_idx_d   = idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
          sp_wdata_d = wide_data_s[63:32];
          sp_be_d    = wide_be_s[7:4];
          sp_lo_d    = mem_q[idx_s];
        end else begin
          mem_we_s    = req_we_i;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = req_we_i ? 32'h0000_0000 : load_ext(req_funct3_i, lo_rd_s);
        end
      end
      ST_SPLIT: begin
        mem_we_s    = sp_we_q;
        mem_widx_s  = sp_idx_q;
        mem_wdata_s = sp_wdata_q;
        mem_be_s    = sp_be_q;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = sp_we_q ? 32'h0000_0000 : load_ext(sp_f3_q, hi_asm_s);
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Control, response and split-capture registers
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      if (CLEAR_ON_RESET) begin
        state_q <= ST_INIT;
      end else begin
        state_q <= ST_IDLE;
      end
      clr_cnt_q   <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      sp_we_q     <= 1'b0;
      sp_f3_q     <= 3'b000;
      sp_lane_q   <= 2'b00;
      sp_idx_q    <= '0;
      sp_wdata_q  <= 32'h0000_0000;
      sp_be_q     <= 4'h0;
      sp_lo_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      sp_we_q     <= sp_we_d;
      sp_f3_q     <= sp_f3_d;
      sp_lane_q   <= sp_lane_d;
      sp_idx_q    <= sp_idx_d;
      sp_wdata_q  <= sp_wdata_d;
      sp_be_q     <= sp_be_d;
      sp_lo_q     <= sp_lo_d;
    end
  end

  // Storage array: byte-enabled single write port, not reset
  always_ff @(posedge sys_clk) begin
    if (mem_we_s) begin
      mem_q[mem_widx_s] <= byte_merge(mem_q[mem_widx_s], mem_wdata_s, mem_be_s);
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed plus randomized bench for data_memory_ctrl against a byte-array reference model.
module tb_data_memory_ctrl;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0, req_wdata_i = 32'h0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o, dbg_data_o;
  logic [7:0]  dbg_idx_i = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [4*DEPTH];

  data_memory_ctrl dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_funct3_i(req_funct3_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .dbg_idx_i(dbg_idx_i), .dbg_data_o(dbg_data_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Expected outcome of one request from the architectural rules
  task automatic model_eval(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                            output bit err, output bit split, output logic [31:0] rdata);
    int  size, o;
    bit  legal;
    size  = acc_size(f3);
    legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) || (!we && (f3 == 3'b100 || f3 == 3'b101));
    err   = !legal || (addr < BASE) || (longint'(addr) - longint'(BASE) + longint'(size) > longint'(4*DEPTH));
    rdata = 32'h0;
    split = 1'b0;
    if (!err) begin
      o     = int'(addr - BASE);
      split = ((o % 4) + size) > 4;
      if (!we) begin
        for (int i = 0; i < size; i++) rdata = rdata | (32'(ref_mem[o+i]) << (8*i));
        if (!f3[2] && size < 4 && rdata[8*size-1]) rdata = rdata | ~((32'h1 << (8*size)) - 32'h1);
      end
    end
  endtask

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    int o;
    o = int'(addr - BASE);
    for (int i = 0; i < acc_size(f3); i++) ref_mem[o+i] = wdata[8*i +: 8];
  endtask

  task automatic check_dbg(input string tag, input int idx);
    dbg_idx_i = 8'(idx);
    #1;
    check32(tag, dbg_data_o, ref_word(idx));
  endtask

  task automatic do_req(input string tag, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, output logic [31:0] got);
    bit          e_err, e_split;
    logic [31:0] e_data;
    int          w;
    model_eval(we, addr, f3, e_err, e_split, e_data);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_funct3_i = f3;
    w = 0;
    while (!req_ready_o && w < 100) begin @(posedge sys_clk); #1; w++; end
    check32({tag, "_ready_wait"}, 32'(w < 100), 32'd1);
    @(posedge sys_clk); #1;
    req_valid_i = 1'b0;
    if (!e_err && we) model_store(addr, wdata, f3);
    if (e_split) begin
      check32({tag, "_split_busy"}, {30'h0, rsp_valid_o, req_ready_o}, 32'd0);
      @(posedge sys_clk); #1;
    end
    check32({tag, "_rsp"}, {29'h0, rsp_valid_o, rsp_err_o, req_ready_o}, {29'h0, 1'b1, e_err, 1'b1});
    check32({tag, "_rdata"}, rsp_rdata_o, e_data);
    got = rsp_rdata_o;
    @(posedge sys_clk); #1;
    check32({tag, "_pulse"}, {31'h0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int n, rsp_seen;
    model_clear();
    #1;
    check32("reset_outs", {rsp_rdata_o[30:0], rsp_valid_o}, 32'd0);
    check32("reset_flags", {30'h0, req_ready_o, rsp_err_o}, 32'd0);
    // request pending during INIT must wait for the sweep
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h400; req_funct3_i = 3'b010;
    #22 sys_reset_n = 1'b1;
    #1 check32("init_ready0", {31'h0, req_ready_o}, 32'd0);
    n = 0;
    while (!req_ready_o && n < 1000) begin
      @(posedge sys_clk); #1; n++;
      check32("init_no_rsp", {31'h0, rsp_valid_o}, 32'd0);
    end
    check32("init_cycles", n, 32'd256);
    @(posedge sys_clk); #1;
    req_valid_i = 1'b0;
    check32("held_req_rsp", {31'h0, rsp_valid_o}, 32'd1);
    check32("held_req_data", rsp_rdata_o, 32'h0);
    check_dbg("dbg0", 0);
    check_dbg("dbg128", 128);
    check_dbg("dbg255", 255);

    do_req("sw400", 1'b1, 32'h400, 32'hDEADBEEF, 3'b010, got);
    do_req("lw400", 1'b0, 32'h400, 32'h0, 3'b010, got);
    check32("lw400_val", got, 32'hDEADBEEF);
    do_req("lb400", 1'b0, 32'h400, 32'h0, 3'b000, got);
    check32("lb400_val", got, 32'hFFFFFFEF);
    do_req("lbu401", 1'b0, 32'h401, 32'h0, 3'b100, got);
    check32("lbu401_val", got, 32'h000000BE);

    do_req("sh403", 1'b1, 32'h403, 32'h00008001, 3'b001, got);
    check_dbg("sh403_w0", 0);
    check32("sh403_w0b3", {24'h0, dbg_data_o[31:24]}, 32'h01);
    check_dbg("sh403_w1", 1);
    check32("sh403_w1b0", {24'h0, dbg_data_o[7:0]}, 32'h80);
    do_req("lh403", 1'b0, 32'h403, 32'h0, 3'b001, got);
    check32("lh403_val", got, 32'hFFFF8001);
    do_req("lhu403", 1'b0, 32'h403, 32'h0, 3'b101, got);
    check32("lhu403_val", got, 32'h00008001);

    do_req("lw3fc_err", 1'b0, 32'h3FC, 32'h0, 3'b010, got);
    do_req("lw7fd_err", 1'b0, 32'h7FD, 32'h0, 3'b010, got);
    do_req("lw7fc_ok", 1'b0, 32'h7FC, 32'h0, 3'b010, got);
    do_req("st011_err", 1'b1, 32'h400, 32'h12345678, 3'b011, got);
    check_dbg("st011_unchanged", 0);

    // back-to-back byte stores, one accept per cycle
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b000;
      req_addr_i = 32'h404 + 32'(i); req_wdata_i = 32'h11 * 32'(i + 1);
      @(posedge sys_clk); #1;
      model_store(req_addr_i, req_wdata_i, 3'b000);
      check32("b2b_rsp", {29'h0, rsp_valid_o, rsp_err_o, req_ready_o}, 32'b101);
      check32("b2b_rdata", rsp_rdata_o, 32'h0);
    end
    req_valid_i = 1'b0;
    @(posedge sys_clk); #1;
    check32("b2b_done", {31'h0, rsp_valid_o}, 32'd0);
    dbg_idx_i = 8'd1; #1;
    check32("b2b_word1", dbg_data_o, 32'h44332211);

    for (int t = 0; t < 150; t++) begin
      do_req("rand", 1'($urandom_range(0, 1)), 32'h3F0 + 32'($urandom_range(0, 32'h420)),
             $urandom, 3'($urandom_range(0, 7)), got);
      check_dbg("rand_dbg", int'($urandom_range(0, DEPTH - 1)));
    end

    // reset in the middle of a split store
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h406; req_wdata_i = 32'hCAFEF00D; req_funct3_i = 3'b010;
    n = 0;
    while (!req_ready_o && n < 100) begin @(posedge sys_clk); #1; n++; end
    @(posedge sys_clk); #1;
    req_valid_i = 1'b0;
    check32("abort_in_split", {30'h0, req_ready_o, rsp_valid_o}, 32'd0);
    sys_reset_n = 1'b0;
    #1 check32("abort_rsp", {31'h0, rsp_valid_o}, 32'd0);
    #20 sys_reset_n = 1'b1;
    n = 0; rsp_seen = 0;
    while (!req_ready_o && n < 1000) begin
      @(posedge sys_clk); #1; n++;
      if (rsp_valid_o) rsp_seen++;
    end
    check32("reinit_cycles", n, 32'd256);
    check32("abort_no_rsp", rsp_seen, 32'd0);
    model_clear();
    dbg_idx_i = 8'd1; #1;
    check32("reinit_w1", dbg_data_o, 32'h0);
    dbg_idx_i = 8'd2; #1;
    check32("reinit_w2", dbg_data_o, 32'h0);
    do_req("post_reset_lw", 1'b0, 32'h404, 32'h0, 3'b010, got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
